// File: rtl/dcache_sram_nway_if.sv
// Lookup/access, flush-control and write-back signals between the dcache controller
// and the N-way storage array.
interface dcache_sram_nway_if #(
    parameter int unsigned SETS   = 16,
    parameter int unsigned TAG_W  = 23,
    parameter int unsigned LINE_W = 256
);
    localparam int unsigned INDEX_W = $clog2(SETS);

    logic [INDEX_W-1:0] addr_i;
    logic [TAG_W+1:0]   tag_i;
    logic [LINE_W-1:0]  data_i;
    logic               enable_i;
    logic               write_i;
    logic [TAG_W+1:0]   tag_o;
    logic [LINE_W-1:0]  data_o;
    logic               hit_o;
    logic               flush_i;
    logic               flush_busy_o;
    logic               flush_done_o;
    logic               wb_valid_o;
    logic               wb_ready_i;
    logic [INDEX_W-1:0] wb_index_o;
    logic [TAG_W-1:0]   wb_tag_o;
    logic [LINE_W-1:0]  wb_data_o;

    modport master (
        output addr_i, tag_i, data_i, enable_i, write_i, flush_i, wb_ready_i,
        input  tag_o, data_o, hit_o, flush_busy_o, flush_done_o,
        input  wb_valid_o, wb_index_o, wb_tag_o, wb_data_o
    );

    modport slave (
        input  addr_i, tag_i, data_i, enable_i, write_i, flush_i, wb_ready_i,
        output tag_o, data_o, hit_o, flush_busy_o, flush_done_o,
        output wb_valid_o, wb_index_o, wb_tag_o, wb_data_o
    );
endinterface

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache tag/data array with true-LRU ages, invalid-first victim
// choice and a flush walker that streams dirty lines out over a valid/ready port.
module dcache_sram_nway #(
    parameter int unsigned SETS   = 16,
    parameter int unsigned WAYS   = 4,
    parameter int unsigned TAG_W  = 23,
    parameter int unsigned LINE_W = 256
) (
    input logic              clk_i,
    input logic              rst_i,
    dcache_sram_nway_if.slave bus
);
    localparam int unsigned INDEX_W = $clog2(SETS);
    localparam int unsigned AGE_W   = $clog2(WAYS);
    localparam int unsigned PTR_W   = INDEX_W + AGE_W;
    localparam int unsigned VB      = TAG_W + 1;
    localparam int unsigned DB      = TAG_W;

    typedef logic [TAG_W+1:0]  tag_t;
    typedef logic [LINE_W-1:0] line_t;
    typedef logic [AGE_W-1:0]  age_t;
    typedef enum logic [1:0] {StIdle, StScan, StEmit, StDone} state_t;

    tag_t  tag_q  [SETS][WAYS];
    line_t data_q [SETS][WAYS];
    age_t  age_q  [SETS][WAYS];

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic               busy_q;
    logic               done_q;
    logic               wb_valid_q;
    logic [INDEX_W-1:0] wb_index_q;
    logic [TAG_W-1:0]   wb_tag_q;
    line_t              wb_data_q;

    logic [INDEX_W-1:0] set_idx;
    logic [WAYS-1:0]    way_hit;
    logic               any_hit;
    age_t               hit_way;
    age_t               victim_way;
    age_t               sel_way;

    assign set_idx = bus.addr_i;

    always_comb begin
        way_hit    = '0;
        any_hit    = 1'b0;
        hit_way    = '0;
        victim_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_hit[w] = tag_q[set_idx][w][VB] &&
                         (tag_q[set_idx][w][TAG_W-1:0] == bus.tag_i[TAG_W-1:0]);
        end
        // Downward scans so the lowest-index match wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit[w]) begin
                hit_way = age_t'(w);
                any_hit = 1'b1;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[set_idx][w] == age_t'(WAYS - 1)) begin
                victim_way = age_t'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!tag_q[set_idx][w][VB]) begin
                victim_way = age_t'(w);
            end
        end
        sel_way = any_hit ? hit_way : victim_way;
    end

    assign bus.hit_o        = any_hit && !busy_q;
    assign bus.tag_o        = tag_q[set_idx][sel_way];
    assign bus.data_o       = data_q[set_idx][sel_way];
    assign bus.flush_busy_o = busy_q;
    assign bus.flush_done_o = done_q;
    assign bus.wb_valid_o   = wb_valid_q;
    assign bus.wb_index_o   = wb_index_q;
    assign bus.wb_tag_o     = wb_tag_q;
    assign bus.wb_data_o    = wb_data_q;

    // Walker pointer is {set, way} so incrementing steps the way first.
    logic [INDEX_W-1:0] ptr_set;
    age_t               ptr_way;
    tag_t               scan_tag;
    logic               scan_dirty;
    logic               ptr_last;

    assign ptr_set    = ptr_q[PTR_W-1:AGE_W];
    assign ptr_way    = ptr_q[AGE_W-1:0];
    assign scan_tag   = tag_q[ptr_set][ptr_way];
    assign scan_dirty = scan_tag[VB] && scan_tag[DB];
    assign ptr_last   = &ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                    age_q[s][w]  <= age_t'(w);
                end
            end
            state_q    <= StIdle;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_index_q <= '0;
            wb_tag_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.enable_i && (any_hit || bus.write_i)) begin
                        if (bus.write_i) begin
                            data_q[set_idx][sel_way] <= bus.data_i;
                            if (any_hit) begin
                                tag_q[set_idx][sel_way][VB] <= 1'b1;
                                tag_q[set_idx][sel_way][DB] <= 1'b1;
                            end else begin
                                tag_q[set_idx][sel_way] <= bus.tag_i;
                            end
                        end
                        for (int w = 0; w < WAYS; w++) begin
                            if (age_q[set_idx][w] < age_q[set_idx][sel_way]) begin
                                age_q[set_idx][w] <= age_q[set_idx][w] + 1'b1;
                            end
                        end
                        age_q[set_idx][sel_way] <= '0;
                    end
                    if (bus.flush_i) begin
                        state_q <= StScan;
                        busy_q  <= 1'b1;
                        ptr_q   <= '0;
                    end
                end
                StScan: begin
                    if (scan_dirty) begin
                        state_q    <= StEmit;
                        wb_valid_q <= 1'b1;
                        wb_index_q <= ptr_set;
                        wb_tag_q   <= scan_tag[TAG_W-1:0];
                        wb_data_q  <= data_q[ptr_set][ptr_way];
                    end else if (ptr_last) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                StEmit: begin
                    if (bus.wb_ready_i) begin
                        tag_q[ptr_set][ptr_way][DB] <= 1'b0;
                        wb_valid_q <= 1'b0;
                        wb_index_q <= '0;
                        wb_tag_q   <= '0;
                        wb_data_q  <= '0;
                        if (ptr_last) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StScan;
                            ptr_q   <= ptr_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_sram_nway.sv
// Randomised and directed bench for dcache_sram_nway against a recency-list cache model
// with a cycle-exact flush timeline.
module tb_dcache_sram_nway;
    localparam int SETS = 16, WAYS = 4, TAG_W = 23, LINE_W = 256, IW = 4;
    localparam int SW = SETS * WAYS;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [TAG_W-1:0]  tagv_t;
    typedef logic [TAG_W+1:0]  tagf_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    dcache_sram_nway_if #(.SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) bus ();

    dcache_sram_nway #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input line_t act, input line_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit    m_valid [SETS][WAYS];
    bit    m_dirty [SETS][WAYS];
    tagv_t m_tag   [SETS][WAYS];
    line_t m_data  [SETS][WAYS];
    int    m_order [SETS][WAYS]; // rank -> way, rank 0 = most recently used
    bit    m_busy;
    int    m_t, m_eacc;
    typedef struct {int pos; int set; int way; tagv_t tag; line_t data;} wb_t;
    wb_t   m_q[$];

    function automatic int m_hit_way(input int s, input tagv_t t);
        for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) return w;
        return -1;
    endfunction

    function automatic int m_victim(input int s);
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
        return m_order[s][WAYS-1];
    endfunction

    task automatic m_touch(input int s, input int u);
        int r = 0;
        for (int i = 0; i < WAYS; i++) if (m_order[s][i] == u) r = i;
        for (int i = r; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = u;
    endtask

    task automatic m_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = '0; m_data[s][w] = '0;
                m_order[s][w] = w;
            end
        m_busy = 0; m_t = 0; m_eacc = 0; m_q.delete();
    endtask

    function automatic bit m_exp_valid();
        return m_q.size() > 0 && m_t >= m_q[0].pos + m_eacc + 1;
    endfunction

    function automatic bit m_exp_done();
        return m_q.size() == 0 && m_t == SW + m_eacc;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_reset();
        end else if (!m_busy) begin
            int s, h, v;
            s = int'(bus.addr_i);
            h = m_hit_way(s, bus.tag_i[TAG_W-1:0]);
            if (bus.enable_i) begin
                if (h >= 0) begin
                    if (bus.write_i) begin
                        m_data[s][h] = bus.data_i; m_valid[s][h] = 1; m_dirty[s][h] = 1;
                    end
                    m_touch(s, h);
                end else if (bus.write_i) begin
                    v = m_victim(s);
                    m_valid[s][v] = bus.tag_i[TAG_W+1];
                    m_dirty[s][v] = bus.tag_i[TAG_W];
                    m_tag[s][v]   = bus.tag_i[TAG_W-1:0];
                    m_data[s][v]  = bus.data_i;
                    m_touch(s, v);
                end
            end
            if (bus.flush_i) begin
                m_q.delete();
                for (int p = 0; p < SW; p++) begin
                    wb_t e;
                    e.pos = p; e.set = p / WAYS; e.way = p % WAYS;
                    e.tag = m_tag[e.set][e.way]; e.data = m_data[e.set][e.way];
                    if (m_valid[e.set][e.way] && m_dirty[e.set][e.way]) m_q.push_back(e);
                end
                m_busy = 1; m_t = 0; m_eacc = 0;
            end
        end else begin
            if (m_exp_valid() && bus.wb_ready_i) begin
                m_dirty[m_q[0].set][m_q[0].way] = 0;
                m_eacc = m_t - m_q[0].pos;
                void'(m_q.pop_front());
            end
            if (m_exp_done()) m_busy = 0;
            else m_t++;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            if (!m_busy) begin
                int s, h, e;
                s = int'(bus.addr_i);
                h = m_hit_way(s, bus.tag_i[TAG_W-1:0]);
                e = (h >= 0) ? h : m_victim(s);
                check("hit_o", line_t'(bus.hit_o), line_t'(h >= 0));
                check("tag_o", line_t'(bus.tag_o), line_t'({m_valid[s][e], m_dirty[s][e], m_tag[s][e]}));
                check("data_o", bus.data_o, m_data[s][e]);
                check("busy_idle", line_t'(bus.flush_busy_o), '0);
                check("done_idle", line_t'(bus.flush_done_o), '0);
                check("wb_valid_idle", line_t'(bus.wb_valid_o), '0);
                check("wb_zero_idle", line_t'({bus.wb_index_o, bus.wb_tag_o}) | bus.wb_data_o, '0);
            end else begin
                bit ev;
                ev = m_exp_valid();
                check("busy", line_t'(bus.flush_busy_o), line_t'(1));
                check("hit_busy", line_t'(bus.hit_o), '0);
                check("done", line_t'(bus.flush_done_o), line_t'(m_exp_done()));
                check("wb_valid", line_t'(bus.wb_valid_o), line_t'(ev));
                check("wb_index", line_t'(bus.wb_index_o), ev ? line_t'(m_q[0].set) : '0);
                check("wb_tag", line_t'(bus.wb_tag_o), ev ? line_t'(m_q[0].tag) : '0);
                check("wb_data", bus.wb_data_o, ev ? m_data[m_q[0].set][m_q[0].way] : '0);
            end
        end
    end

    // ---------------- event monitor for directed literals ----------------
    int    busy_cnt, done_cnt, idx2_cnt;
    int    hs_idx[$];
    tagv_t hs_tag[$];
    line_t hs_data[$];

    always @(negedge clk) begin
        if (bus.flush_busy_o) busy_cnt++;
        if (bus.flush_done_o) done_cnt++;
        if (bus.wb_valid_o && bus.wb_index_o == 2) idx2_cnt++;
        if (bus.wb_valid_o && bus.wb_ready_i) begin
            hs_idx.push_back(int'(bus.wb_index_o));
            hs_tag.push_back(bus.wb_tag_o);
            hs_data.push_back(bus.wb_data_o);
        end
    end

    task automatic clr_mon();
        busy_cnt = 0; done_cnt = 0; idx2_cnt = 0;
        hs_idx.delete(); hs_tag.delete(); hs_data.delete();
    endtask

    // ---------------- driver helpers ----------------
    logic  lit_hit;
    tagf_t lit_tag;
    line_t lit_data;

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic op(input int s, input tagf_t t, input line_t d, input bit en, input bit wr);
        bus.addr_i = IW'(s); bus.tag_i = t; bus.data_i = d;
        bus.enable_i = en; bus.write_i = wr;
        @(negedge clk);
        lit_hit = bus.hit_o; lit_tag = bus.tag_o; lit_data = bus.data_o;
        @(posedge clk); #1;
        bus.enable_i = 0; bus.write_i = 0;
    endtask

    task automatic do_reset();
        rst = 1; bus.enable_i = 0; bus.write_i = 0; bus.flush_i = 0;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic pulse_flush();
        bus.flush_i = 1;
        @(posedge clk); #1;
        bus.flush_i = 0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.flush_busy_o) return;
        end
        total++; bad++;
        $display("FAIL flush_timeout: busy still 1 after %0d cycles, expected 0", budget);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.wb_valid_o) return;
        end
        total++; bad++;
        $display("FAIL wb_valid_timeout: wb_valid 0 after %0d cycles, expected 1", budget);
    endtask

    localparam tagv_t T21 = 23'h02_0001, T93 = 23'h09_0003;
    line_t d21, d93;

    task automatic setup_dirty();
        d21 = rand_line(); d93 = rand_line();
        op(2, {2'b10, 23'h02_0000}, rand_line(), 1, 1);
        op(2, {2'b11, T21}, d21, 1, 1);
        op(9, {2'b10, 23'h09_0000}, rand_line(), 1, 1);
        op(9, {2'b10, 23'h09_0001}, rand_line(), 1, 1);
        op(9, {2'b10, 23'h09_0002}, rand_line(), 1, 1);
        op(9, {2'b11, T93}, d93, 1, 1);
    endtask

    localparam tagv_t TA = 23'h00A, TB = 23'h00B, TC = 23'h00C, TD = 23'h00D, TE = 23'h00E;

    initial begin
        line_t de, aa;
        bus.addr_i = '0; bus.tag_i = '0; bus.data_i = '0; bus.enable_i = 0;
        bus.write_i = 0; bus.flush_i = 0; bus.wb_ready_i = 0;
        clr_mon();
        @(posedge clk); #1;
        rst = 0; chk_en = 1;

        // Reset state
        op(3, {2'b00, 23'h001234}, '0, 0, 0);
        check("t1_hit", line_t'(lit_hit), '0);
        check("t1_tag", line_t'(lit_tag), '0);
        check("t1_data", lit_data, '0);
        check("t1_busy", line_t'(bus.flush_busy_o), '0);

        // LRU replacement in set 5
        op(5, {2'b10, TA}, rand_line(), 1, 1);
        op(5, {2'b10, TB}, rand_line(), 1, 1);
        op(5, {2'b10, TC}, rand_line(), 1, 1);
        op(5, {2'b10, TD}, rand_line(), 1, 1);
        op(5, {2'b10, TA}, '0, 1, 0);
        check("t2_hitA", line_t'(lit_hit), line_t'(1));
        op(5, {2'b10, TE}, '0, 1, 0);
        check("t2_victimB", line_t'(lit_tag), line_t'({2'b10, TB}));
        de = rand_line();
        op(5, {2'b10, TE}, de, 1, 1);
        op(5, {2'b10, TB}, '0, 1, 0);
        check("t2_missB", line_t'(lit_hit), '0);
        check("t2_victimC", line_t'(lit_tag), line_t'({2'b10, TC}));
        op(5, {2'b10, TE}, '0, 1, 0);
        check("t2_hitE", line_t'(lit_tag), line_t'({2'b10, TE}));
        check("t2_dataE", lit_data, de);
        op(5, {2'b10, TA}, '0, 1, 0); check("t2_hitA2", line_t'(lit_hit), line_t'(1));
        op(5, {2'b10, TC}, '0, 1, 0); check("t2_hitC", line_t'(lit_hit), line_t'(1));
        op(5, {2'b10, TD}, '0, 1, 0); check("t2_hitD", line_t'(lit_hit), line_t'(1));

        // Write hit marks dirty, keeps tag
        aa = {8{32'hAAAA_AAAA}};
        op(5, {2'b00, TC}, aa, 1, 1);
        op(5, {2'b00, TC}, '0, 1, 0);
        check("t3_hit", line_t'(lit_hit), line_t'(1));
        check("t3_tag", line_t'(lit_tag), line_t'({2'b11, TC}));
        check("t3_data", lit_data, aa);

        // Flush with ready tied high
        do_reset();
        setup_dirty();
        bus.wb_ready_i = 1;
        clr_mon();
        pulse_flush();
        wait_idle(300);
        check("t4_busy_cycles", line_t'(busy_cnt), line_t'(67));
        check("t4_done_pulses", line_t'(done_cnt), line_t'(1));
        check("t4_hs_count", line_t'(hs_idx.size()), line_t'(2));
        if (hs_idx.size() == 2) begin
            check("t4_hs0_idx", line_t'(hs_idx[0]), line_t'(2));
            check("t4_hs0_tag", line_t'(hs_tag[0]), line_t'(T21));
            check("t4_hs0_data", hs_data[0], d21);
            check("t4_hs1_idx", line_t'(hs_idx[1]), line_t'(9));
            check("t4_hs1_tag", line_t'(hs_tag[1]), line_t'(T93));
            check("t4_hs1_data", hs_data[1], d93);
        end
        op(2, {2'b10, T21}, '0, 1, 0);
        check("t4_after2", line_t'({lit_hit, lit_tag}), line_t'({1'b1, 2'b10, T21}));
        op(9, {2'b10, T93}, '0, 1, 0);
        check("t4_after9", line_t'({lit_hit, lit_tag}), line_t'({1'b1, 2'b10, T93}));

        // Back-pressure and ignored writes during the flush
        do_reset();
        setup_dirty();
        bus.wb_ready_i = 0;
        clr_mon();
        pulse_flush();
        wait_valid(100);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.addr_i = 2; bus.tag_i = {2'b10, T21}; bus.data_i = rand_line();
            bus.enable_i = 1; bus.write_i = 1;
            if (i == 2) bus.wb_ready_i = 1;
        end
        @(posedge clk); #1;
        bus.enable_i = 0; bus.write_i = 0;
        wait_idle(300);
        check("t5_busy_cycles", line_t'(busy_cnt), line_t'(70));
        check("t5_idx2_cycles", line_t'(idx2_cnt), line_t'(4));
        check("t5_done_pulses", line_t'(done_cnt), line_t'(1));
        op(2, {2'b10, T21}, '0, 1, 0);
        check("t5_data_kept", lit_data, d21);
        check("t5_tag_clean", line_t'(lit_tag), line_t'({2'b10, T21}));

        // Reset in the middle of an emit
        do_reset();
        setup_dirty();
        bus.wb_ready_i = 0;
        pulse_flush();
        wait_valid(100);
        rst = 1;
        @(posedge clk); #1;
        clr_mon();
        check("t6_wb_valid", line_t'(bus.wb_valid_o), '0);
        check("t6_busy", line_t'(bus.flush_busy_o), '0);
        rst = 0;
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        check("t6_no_done", line_t'(done_cnt), '0);
        op(2, {2'b10, T21}, '0, 1, 0); check("t6_miss2", line_t'(lit_hit), '0);
        op(9, {2'b10, T93}, '0, 1, 0); check("t6_miss9", line_t'(lit_hit), '0);

        // Random traffic with occasional flushes and random back-pressure
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int s;
            s = ($urandom % 4 == 0) ? int'($urandom % SETS) : int'($urandom % 4);
            bus.addr_i = IW'(s);
            bus.tag_i = {($urandom % 10 != 0), 1'($urandom), TAG_W'($urandom % 6)};
            bus.data_i = rand_line();
            bus.enable_i = ($urandom % 100) < 85;
            bus.write_i = 1'($urandom);
            bus.flush_i = ($urandom % 120) == 0;
            bus.wb_ready_i = 1'($urandom);
            @(posedge clk); #1;
        end
        bus.enable_i = 0; bus.write_i = 0; bus.flush_i = 0; bus.wb_ready_i = 1;
        wait_idle(500);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
